// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and constants for the multi-cycle data memory controller.
// Optional build macro: DMEM_BOUNDS_CHECK_EN (out-of-range access reporting).
package data_memory_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_dmem_array.sv
// Single-port word RAM: synchronous write, registered read, no reset so it
// maps onto block RAM.
module data_memory_ctrl_dmem_array
    import data_memory_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Multi-cycle data memory behind the data cache: latency counter, one-deep
// pending read slot. Optional build macro: DMEM_BOUNDS_CHECK_EN.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2    = 8,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemReadStart,
    input  logic [31:0]       MemReadAddr,
    output logic [WORD_W-1:0] MemReadData,
    output logic              MemReadFinish,
    input  logic              MemWriteStart,
    input  logic [31:0]       MemWriteAddr,
    input  logic [WORD_W-1:0] MemWriteData,
    output logic              MemWriteFinish,
    output logic              Busy
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    output logic              AccessError
`endif
);

    localparam int CNT_W = $clog2(max_int(READ_LATENCY, WRITE_LATENCY) + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
    logic                  rd_oob, wr_oob;

    assign rd_idx = MemReadAddr[DEPTH_LOG2+1:2];
    assign wr_idx = MemWriteAddr[DEPTH_LOG2+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign rd_oob = |MemReadAddr[31:DEPTH_LOG2+2];
    assign wr_oob = |MemWriteAddr[31:DEPTH_LOG2+2];
    logic unused_addr_bits;
    assign unused_addr_bits = ^{MemReadAddr[1:0], MemWriteAddr[1:0]};
`else
    // Upper address bits alias into the array in this build.
    assign rd_oob = 1'b0;
    assign wr_oob = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{MemReadAddr[31:DEPTH_LOG2+2], MemReadAddr[1:0],
                                MemWriteAddr[31:DEPTH_LOG2+2], MemWriteAddr[1:0]};
`endif

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [DEPTH_LOG2-1:0] pend_idx_q, pend_idx_d;
    logic                  pend_oob_q, pend_oob_d;
    logic [DEPTH_LOG2-1:0] acc_idx_q, acc_idx_d;
    logic                  acc_oob_q, acc_oob_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  rd_fin_q, rd_fin_d;
    logic                  wr_fin_q, wr_fin_d;
    logic                  err_q, err_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_err_q, rd_err_d;

    logic                  ram_we, ram_re;
    logic [WORD_W-1:0]     ram_rdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        pend_oob_d = pend_oob_q;
        acc_idx_d  = acc_idx_q;
        acc_oob_d  = acc_oob_q;
        wdata_d    = wdata_q;
        rd_fin_d   = 1'b0;
        wr_fin_d   = 1'b0;
        err_d      = 1'b0;
        rd_valid_d = rd_valid_q;
        rd_err_d   = rd_err_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        case (state_q)
            IDLE: begin
                // A queued read goes first; new starts while it is queued are dropped.
                if (pend_q) begin
                    acc_idx_d = pend_idx_q;
                    acc_oob_d = pend_oob_q;
                    pend_d    = 1'b0;
                    cnt_d     = RD_LOAD;
                    state_d   = READ_WAIT;
                end else if (MemWriteStart) begin
                    acc_idx_d = wr_idx;
                    acc_oob_d = wr_oob;
                    wdata_d   = MemWriteData;
                    cnt_d     = WR_LOAD;
                    state_d   = WRITE_WAIT;
                    if (MemReadStart) begin
                        pend_d     = 1'b1;
                        pend_idx_d = rd_idx;
                        pend_oob_d = rd_oob;
                    end
                end else if (MemReadStart) begin
                    acc_idx_d = rd_idx;
                    acc_oob_d = rd_oob;
                    cnt_d     = RD_LOAD;
                    state_d   = READ_WAIT;
                end
            end
            READ_WAIT, WRITE_WAIT: begin
                if (MemReadStart && !pend_q) begin
                    pend_d     = 1'b1;
                    pend_idx_d = rd_idx;
                    pend_oob_d = rd_oob;
                end
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    err_d   = acc_oob_q;
                    if (state_q == READ_WAIT) begin
                        ram_re     = 1'b1;
                        rd_fin_d   = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_err_d   = acc_oob_q;
                    end else begin
                        ram_we   = !acc_oob_q;
                        wr_fin_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            pend_oob_q <= 1'b0;
            acc_idx_q  <= '0;
            acc_oob_q  <= 1'b0;
            wdata_q    <= '0;
            rd_fin_q   <= 1'b0;
            wr_fin_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            pend_oob_q <= pend_oob_d;
            acc_idx_q  <= acc_idx_d;
            acc_oob_q  <= acc_oob_d;
            wdata_q    <= wdata_d;
            rd_fin_q   <= rd_fin_d;
            wr_fin_q   <= wr_fin_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    data_memory_ctrl_dmem_array #(
        .ADDR_W(DEPTH_LOG2)
    ) u_array (
        .clk  (CLK),
        .we   (ram_we),
        .re   (ram_re),
        .addr (acc_idx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    // The RAM output register has no reset, so gate it until the first read lands.
    assign MemReadData    = !rd_valid_q ? '0 : (rd_err_q ? ERR_DATA : ram_rdata);
    assign MemReadFinish  = rd_fin_q;
    assign MemWriteFinish = wr_fin_q;
    assign Busy           = (state_q != IDLE) || pend_q;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign AccessError = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl against a word-array reference model.
module tb_data_memory_ctrl;

    localparam int DL = 8;
    localparam int RL = 4;
    localparam int WL = 4;
    localparam int NW = 1 << DL;
    localparam int OBS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_start, wr_start;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [31:0] rd_data;
    logic        rd_fin, wr_fin, busy;
    logic        access_error;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [0:NW-1];

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DEPTH_LOG2   (DL),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .CLK           (clk),
        .Reset         (rst),
        .MemReadStart  (rd_start),
        .MemReadAddr   (rd_addr),
        .MemReadData   (rd_data),
        .MemReadFinish (rd_fin),
        .MemWriteStart (wr_start),
        .MemWriteAddr  (wr_addr),
        .MemWriteData  (wr_data),
        .MemWriteFinish(wr_fin),
        .Busy          (busy)
`ifdef DMEM_BOUNDS_CHECK_EN
        ,
        .AccessError   (access_error)
`endif
    );

`ifndef DMEM_BOUNDS_CHECK_EN
    assign access_error = 1'b0;
`endif

    function automatic bit is_oob(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
        return a[31:DL+2] != '0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (is_oob(a)) return 32'hDEADBEEF;
        return ref_mem[a[DL+1:2]];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (!is_oob(a)) ref_mem[a[DL+1:2]] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Starts are driven at negedge index wr_c / rd_c (-1 = the negedge just before
    // edge 0) and sampled by the following rising edge. Index c >= 0 observes the
    // cycle between edge c and edge c+1.
    task automatic run(input int wr_c, input logic [31:0] wa, input logic [31:0] wd,
                       input int rd_c, input logic [31:0] ra,
                       output int wr_at, output int rd_at, output int n_wr, output int n_rd,
                       output logic [31:0] rdat, output logic [31:0] rhold,
                       output logic werr, output logic rerr,
                       output logic [OBS-1:0] busy_hist);
        wr_at = -1; rd_at = -1; n_wr = 0; n_rd = 0;
        rdat = '0; werr = 1'b0; rerr = 1'b0; busy_hist = '0;
        for (int c = -1; c < OBS; c++) begin
            @(negedge clk);
            if (c >= 0) begin
                busy_hist[c] = busy;
                if (wr_fin === 1'b1) begin
                    n_wr++;
                    if (wr_at < 0) begin wr_at = c; werr = access_error; end
                end
                if (rd_fin === 1'b1) begin
                    n_rd++;
                    if (rd_at < 0) begin rd_at = c; rdat = rd_data; rerr = access_error; end
                end
            end
            wr_start = (c == wr_c);
            rd_start = (c == rd_c);
            wr_addr  = wa;
            wr_data  = wd;
            rd_addr  = ra;
        end
        rhold = rd_data;
        wr_start = 1'b0;
        rd_start = 1'b0;
    endtask

    task automatic txn_write(input logic [31:0] a, input logic [31:0] d);
        int wa, ra, nw, nr;
        logic [31:0] rdat, rhold;
        logic werr, rerr;
        logic [OBS-1:0] bh;
        run(-1, a, d, -9, 32'h0, wa, ra, nw, nr, rdat, rhold, werr, rerr, bh);
        chk("wr_latency", 32'(wa), 32'(WL));
        chk("wr_pulse_count", 32'(nw), 32'd1);
        chk("wr_busy_end", {31'd0, bh[OBS-1]}, 32'd0);
        chk("wr_error", {31'd0, werr}, {31'd0, is_oob(a)});
        model_write(a, d);
        $display("txn write addr=%h data=%h finish_at=%0d err=%0d", a, d, wa, werr);
    endtask

    task automatic txn_read(input logic [31:0] a);
        int wa, ra, nw, nr;
        logic [31:0] rdat, rhold, exp;
        logic werr, rerr;
        logic [OBS-1:0] bh;
        exp = model_read(a);
        run(-9, 32'h0, 32'h0, -1, a, wa, ra, nw, nr, rdat, rhold, werr, rerr, bh);
        chk("rd_latency", 32'(ra), 32'(RL));
        chk("rd_pulse_count", 32'(nr), 32'd1);
        chk("rd_data", rdat, exp);
        chk("rd_data_held", rhold, exp);
        chk("rd_error", {31'd0, rerr}, {31'd0, is_oob(a)});
        $display("txn read  addr=%h data=%h finish_at=%0d err=%0d", a, rdat, ra, rerr);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rdata"}, rd_data, 32'h0);
        chk({tag, "_rfin"}, {31'd0, rd_fin}, 32'd0);
        chk({tag, "_wfin"}, {31'd0, wr_fin}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_err"}, {31'd0, access_error}, 32'd0);
    endtask

    initial begin
        int wa, ra, nw, nr, spurious;
        logic [31:0] rdat, rhold, a, d;
        logic werr, rerr;
        logic [OBS-1:0] bh;

        rst = 1'b1; rd_start = 1'b0; wr_start = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        for (int i = 0; i < NW; i++) begin
            txn_write(32'(i) << 2, $urandom);
        end

        // Read latency and byte offset
        txn_write(32'h14, 32'h12345678);
        txn_read(32'h14);
        txn_read(32'h17);

        // Write then readback
        txn_write(32'h20, 32'hA5A5A5A5);
        txn_read(32'h20);

        // Simultaneous write and read at the same address
        run(-1, 32'h40, 32'hCAFEF00D, -1, 32'h40, wa, ra, nw, nr, rdat, rhold, werr, rerr, bh);
        model_write(32'h40, 32'hCAFEF00D);
        chk("sim_wr_at", 32'(wa), 32'(WL));
        chk("sim_rd_at", 32'(ra), 32'(WL + 1 + RL));
        chk("sim_rd_data", rdat, 32'hCAFEF00D);
        chk("sim_busy_window", {23'd0, bh[WL+RL:0]}, {23'd0, {(WL+RL+1){1'b1}}});
        chk("sim_busy_after", {31'd0, bh[WL+RL+1]}, 32'd0);
        $display("txn simul addr=00000040 wr_at=%0d rd_at=%0d data=%h", wa, ra, rdat);

        // Read arriving mid-write is queued behind it
        run(-1, 32'h60, 32'h0BADF00D, 1, 32'h60, wa, ra, nw, nr, rdat, rhold, werr, rerr, bh);
        model_write(32'h60, 32'h0BADF00D);
        chk("queued_wr_at", 32'(wa), 32'(WL));
        chk("queued_rd_at", 32'(ra), 32'(WL + 1 + RL));
        chk("queued_rd_data", rdat, 32'h0BADF00D);
        $display("txn queue addr=00000060 wr_at=%0d rd_at=%0d data=%h", wa, ra, rdat);

        // Write arriving mid-read is dropped
        d = model_read(32'h70);
        run(1, 32'h70, ~d, -1, 32'h70, wa, ra, nw, nr, rdat, rhold, werr, rerr, bh);
        chk("drop_rd_at", 32'(ra), 32'(RL));
        chk("drop_wr_count", 32'(nw), 32'd0);
        chk("drop_rd_data", rdat, d);
        $display("txn drop  addr=00000070 rd_at=%0d writes=%0d", ra, nw);
        txn_read(32'h70);

        // Reset two cycles into a write
        @(negedge clk);
        wr_start = 1'b1; wr_addr = 32'h8; wr_data = 32'hFFFFFFFF;
        @(negedge clk);
        wr_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rd_fin === 1'b1 || wr_fin === 1'b1 || busy === 1'b1) spurious++;
        end
        chk("reset_no_finish", 32'(spurious), 32'd0);
        chk_idle_outputs("after_abort");
        $display("txn reset addr=00000008 aborted");
        txn_read(32'h8);

`ifdef DMEM_BOUNDS_CHECK_EN
        txn_read(32'h00000400);
        txn_write(32'h00000400, 32'h11111111);
        txn_read(32'h00000000);
`else
        txn_write(32'h00000400, 32'h11111111);
        txn_read(32'h00000000);
`endif

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            if ($urandom_range(1, 0) == 1) a[31:DL+2] = '0;
            if ($urandom_range(1, 0) == 1) txn_write(a, $urandom);
            else txn_read(a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Multi-cycle data memory that sits directly downstream of the 4-way associative data cache. It serves the cache's miss refills and write-backs over the MemRead*/MemWrite* start/finish handshake. Access latency is parameterised, so cache miss-penalty behaviour can be exercised realistically. The block is a word-addressed storage array with a small control FSM; it holds at most one queued read behind a write.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words in the array (256 words by default).
- READ_LATENCY, 4, cycles from an accepted read start to MemReadFinish. Must be ≥1.
- WRITE_LATENCY, 4, cycles from an accepted write start to MemWriteFinish. Must be ≥1.

Ports:
- CLK, input, 1, system clock; all logic is on the rising edge.
- Reset, input, 1, asynchronous, active-high reset.
- MemReadStart, input, 1, read request pulse from the cache.
- MemReadAddr, input, 32, byte address of the read.
- MemReadData, output, 32, read data; valid while MemReadFinish=1 and held afterwards.
- MemReadFinish, output, 1, one-cycle pulse marking read completion.
- MemWriteStart, input, 1, write request pulse from the cache.
- MemWriteAddr, input, 32, byte address of the write.
- MemWriteData, input, 32, write data.
- MemWriteFinish, output, 1, one-cycle pulse marking write completion.
- Busy, output, 1, high in any state other than IDLE, or while a read is pending.

Behaviour:
- Reset values:
  - MemReadData=0, MemReadFinish=0, MemWriteFinish=0, Busy=0.
  - FSM=IDLE, counter=0, pending-read flag=0.
  - Array contents are not reset.
- Addressing: word index = Addr[DEPTH_LOG2+1:2]. Bits [1:0] are ignored; upper bits are ignored unless the optional feature is enabled.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT.
- IDLE:
  - MemWriteStart=1: latch the write address and data, load the counter with WRITE_LATENCY-1, go to WRITE_WAIT.
  - Otherwise, MemReadStart=1 or pending=1: latch the read address (the pending address if pending=1), load the counter with READ_LATENCY-1, clear pending, go to READ_WAIT.
- Simultaneous MemWriteStart and MemReadStart in IDLE:
  - The write is accepted first (dirty-victim write-back before refill).
  - The read address is latched into the pending slot, and pending=1.
- READ_WAIT:
  - Decrement the counter each cycle.
  - On the edge where counter==0, register MemReadData from the array and assert MemReadFinish for exactly one cycle.
  - Return to IDLE on the same edge.
- WRITE_WAIT:
  - Decrement the counter each cycle.
  - On the edge where counter==0, commit the data to the array and assert MemWriteFinish for one cycle.
  - Return to IDLE.
- Latency: a start sampled at edge N produces its finish pulse high during the cycle after edge N+LATENCY.
  - Example: READ_LATENCY=4, start sampled at edge 0 → finish high between edges 4 and 5.
- Queued read: a pending read is launched from IDLE on the edge after MemWriteFinish. It therefore sees the just-written data.
- Starts arriving while Busy=1:
  - A MemReadStart is captured into the pending slot only if the slot is empty.
  - A MemReadStart arriving when the slot is full is dropped.
  - A MemWriteStart is dropped.
  - The cache protocol guarantees it waits for a finish, so drops are only a safety net.
- Counter width: $clog2(max(READ_LATENCY, WRITE_LATENCY)+1).
- Reset mid-operation aborts the access immediately:
  - An in-flight write never commits.
  - No finish pulse is generated.
  - Pending is cleared.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- When defined:
  - Adds output AccessError (1 bit, reset 0), pulsed alongside the finish of any access whose Addr[31:DEPTH_LOG2+2] is nonzero.
  - Such a write does not commit.
  - Such a read returns 32'hDEADBEEF.
- When undefined: no AccessError port; upper address bits alias into the array.

Decomposition:
- Shared package (e.g. mem_pkg):
  - FSM state typedef (IDLE/READ_WAIT/WRITE_WAIT).
  - Word width constant (32).
  - Error read value 32'hDEADBEEF.
- Natural sub-module: dmem_array, a single-port synchronous-write RAM with registered read.
- The controller FSM, counter and pending slot live in data_memory_ctrl.

Test Plan:
- Read latency: preload word 5=32'h12345678; pulse MemReadStart with addr 32'h14 → MemReadFinish one cycle wide, 4 cycles later; MemReadData=32'h12345678 and held after.
- Write then readback: write 32'hA5A5A5A5 to 32'h20 → MemWriteFinish after 4 cycles; then read 32'h20 → 32'hA5A5A5A5.
- Simultaneous starts: write 32'hCAFEF00D and read, both at 32'h40, in the same cycle → MemWriteFinish at +4, MemReadFinish at +9 returning 32'hCAFEF00D; Busy continuously high.
- Byte offset: read addr 32'h17 → same data as 32'h14.
- Reset mid-write: Reset asserted 2 cycles into a write of 32'hFFFFFFFF to 32'h8 → no finish pulse, word 2 unchanged, all outputs 0.
- With DMEM_BOUNDS_CHECK_EN: read 32'h0000_0400 → AccessError pulses with finish; data=32'hDEADBEEF. Write to the same address → array unchanged.
